// File: rtl/dmem_dma_pkg.sv
// Shared types for the data-memory copy/fill engine: FSM state encoding and mode values.
package dmem_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/dmem_copy_engine.sv
// Block copy / block fill master for the 16-bit data memory port.
// One word per READ+WRITE pair in copy mode, one word per WRITE in fill mode.
module dmem_copy_engine
  import dmem_dma_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  words_done,
  output logic [ADDR_WIDTH-1:0] mem_access_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_en,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_WIDTH-1:0] dst_ptr_q, dst_ptr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [LEN_WIDTH-1:0]  words_done_q, words_done_d;
  logic                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;
  logic [DATA_WIDTH-1:0] rd_buf_q, rd_buf_d;

  always_comb begin
    state_d         = state_q;
    src_ptr_d       = src_ptr_q;
    dst_ptr_d       = dst_ptr_q;
    rem_d           = rem_q;
    words_done_d    = words_done_q;
    mode_d          = mode_q;
    fill_d          = fill_q;
    rd_buf_d        = rd_buf_q;
    busy            = 1'b0;
    done            = 1'b0;
    mem_read        = 1'b0;
    mem_write_en    = 1'b0;
    mem_access_addr = '0;
    mem_write_data  = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          src_ptr_d    = src_addr;
          dst_ptr_d    = dst_addr;
          rem_d        = length;
          mode_d       = mode;
          fill_d       = fill_value;
          words_done_d = '0;
          if (length == '0)
            state_d = DONE;
          else if (mode == MODE_FILL)
            state_d = WRITE;
          else
            state_d = READ;
        end
      end
      READ: begin
        busy            = 1'b1;
        mem_read        = 1'b1;
        mem_access_addr = src_ptr_q;
        rd_buf_d        = mem_read_data;
        src_ptr_d       = src_ptr_q + ADDR_WIDTH'(1);
        state_d         = WRITE;
      end
      WRITE: begin
        busy            = 1'b1;
        // Gate the strobe so a reset edge can never commit a write.
        mem_write_en    = !rst;
        mem_access_addr = dst_ptr_q;
        mem_write_data  = (mode_q == MODE_FILL) ? fill_q : rd_buf_q;
        dst_ptr_d       = dst_ptr_q + ADDR_WIDTH'(1);
        rem_d           = rem_q - LEN_WIDTH'(1);
        words_done_d    = words_done_q + LEN_WIDTH'(1);
        if (rem_q == LEN_WIDTH'(1))
          state_d = DONE;
        else if (mode_q == MODE_FILL)
          state_d = WRITE;
        else
          state_d = READ;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      src_ptr_q    <= '0;
      dst_ptr_q    <= '0;
      rem_q        <= '0;
      words_done_q <= '0;
      mode_q       <= MODE_COPY;
      fill_q       <= '0;
      rd_buf_q     <= '0;
    end else begin
      state_q      <= state_d;
      src_ptr_q    <= src_ptr_d;
      dst_ptr_q    <= dst_ptr_d;
      rem_q        <= rem_d;
      words_done_q <= words_done_d;
      mode_q       <= mode_d;
      fill_q       <= fill_d;
      rd_buf_q     <= rd_buf_d;
    end
  end

  assign words_done = words_done_q;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Directed bench for dmem_copy_engine with a behavioural 256-word memory and a write scoreboard.
module tb_dmem_copy_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [8:0]  length;
  logic [15:0] fill_value;
  logic        busy;
  logic        done;
  logic [8:0]  words_done;
  logic [15:0] mem_access_addr;
  logic [15:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read;
  logic [15:0] mem_read_data;

  always #5 clk = ~clk;

  dmem_copy_engine dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .mode            (mode),
    .src_addr        (src_addr),
    .dst_addr        (dst_addr),
    .length          (length),
    .fill_value      (fill_value),
    .busy            (busy),
    .done            (done),
    .words_done      (words_done),
    .mem_access_addr (mem_access_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_en    (mem_write_en),
    .mem_read        (mem_read),
    .mem_read_data   (mem_read_data)
  );

  // Responder memory: 8-bit decode, combinational read, write on the clock edge.
  logic [15:0] mem [256];
  logic        mem_init;
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h1000 + 16'(i);
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (mem_write_en) begin
      mem[mem_access_addr[7:0]] <= mem_write_data;
    end
  end

  assign mem_read_data = mem[mem_access_addr[7:0]];

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t         wq[$];
  logic [15:0] exp_mem [256];

  int checks   = 0;
  int failures = 0;
  int cyc_in_op, busy_cnt, done_cnt, done_at;
  logic rd_seen, both_seen;
  logic [8:0] wd_at_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // One clock; sample #1 after the edge and score any write presented this cycle.
  task automatic step();
    wr_t e;
    @(posedge clk);
    #1;
    cyc_in_op++;
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      if (done_at == 0) begin
        done_at    = cyc_in_op;
        wd_at_done = words_done;
      end
    end
    if (mem_read) rd_seen = 1'b1;
    if (mem_read && mem_write_en) both_seen = 1'b1;
    if (mem_write_en) begin
      chk("wr_expected", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        e = wq.pop_front();
        chk("wr_addr", 32'(mem_access_addr), 32'(e.a));
        chk("wr_data", 32'(mem_write_data), 32'(e.d));
      end
    end
  endtask

  task automatic clear_stats();
    cyc_in_op = 0; busy_cnt = 0; done_cnt = 0; done_at = 0;
    rd_seen = 1'b0; both_seen = 1'b0; wd_at_done = '0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
    exp_mem[a] = d;
  endtask

  task automatic check_mem(input string tag);
    int mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) mism++;
    chk(tag, 32'(mism), 32'd0);
  endtask

  task automatic run_op(input logic m, input logic [15:0] src, input logic [15:0] dst,
                        input logic [8:0] len, input logic [15:0] fv, input int glitch);
    logic [15:0] a, d;
    int exp_busy;
    clear_stats();
    for (int i = 0; i < int'(len); i++) begin
      a = dst + 16'(i);
      d = m ? fv : exp_mem[8'(src + 16'(i))];
      exp_mem[a[7:0]] = d;
      wq.push_back('{a: a, d: d});
    end
    exp_busy = (len == 0) ? 0 : (m ? int'(len) : 2 * int'(len));
    start = 1'b1; mode = m; src_addr = src; dst_addr = dst; length = len; fill_value = fv;
    step();
    start = 1'b0;
    while (done_cnt == 0 && cyc_in_op < 1100) begin
      if (cyc_in_op == glitch) begin
        start = 1'b1; mode = ~m; src_addr = 16'h0000; dst_addr = 16'h0090;
        length = 9'd7; fill_value = 16'hDEAD;
        step();
        start = 1'b0;
      end else begin
        step();
      end
    end
    chk("done_seen", 32'(done_cnt), 32'd1);
    chk("done_latency", 32'(done_at), 32'(exp_busy + 1));
    chk("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
    chk("words_done", 32'(wd_at_done), 32'(len));
    step();
    chk("idle_after_done", {28'd0, busy, done, mem_read, mem_write_en}, 32'd0);
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("read_seen", 32'(rd_seen), 32'((m == 1'b0) && (len != 0)));
    chk("rd_wr_overlap", 32'(both_seen), 32'd0);
    chk("scoreboard_empty", 32'(wq.size()), 32'd0);
    check_mem("mem_image");
    $display("op mode=%0d src=%04h dst=%04h len=%0d fill=%04h done_at=%0d busy=%0d",
             m, src, dst, len, fv, done_at, busy_cnt);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    length = '0; fill_value = '0; mem_init = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 256; i++) exp_mem[i] = 16'h1000 + 16'(i);
    clear_stats();
    step();
    mem_init = 1'b0;
    step();
    chk("rst_flags", {28'd0, busy, done, mem_read, mem_write_en}, 32'd0);
    chk("rst_words_done", 32'(words_done), 32'd0);
    chk("rst_addr", 32'(mem_access_addr), 32'd0);
    chk("rst_wdata", 32'(mem_write_data), 32'd0);
    rst = 1'b0;
    step();
    $display("reset released");

    preload(8'h10, 16'h00A1);
    preload(8'h11, 16'h00B2);
    preload(8'h12, 16'h00C3);
    preload(8'h13, 16'h00D4);
    preload(8'h20, 16'h0007);

    // Copy with a stray start (different operands) pulsed mid-operation.
    run_op(1'b0, 16'h0010, 16'h0040, 9'd4, 16'h0000, 3);
    chk("copy_mem43", 32'(mem[8'h43]), 32'h00D4);
    run_op(1'b1, 16'h0000, 16'h0080, 9'd3, 16'hBEEF, 0);
    // Back-to-back: started in the IDLE cycle right after DONE.
    run_op(1'b0, 16'h0020, 16'h0021, 9'd3, 16'h0000, 0);
    chk("overlap_mem23", 32'(mem[8'h23]), 32'h0007);
    run_op(1'b0, 16'h0030, 16'h0050, 9'd0, 16'h0000, 0);
    run_op(1'b1, 16'h0000, 16'h00FE, 9'd4, 16'h5A5A, 0);
    chk("wrap_mem01", 32'(mem[8'h01]), 32'h5A5A);

    // Reset while the third word of a len=5 fill is being presented.
    clear_stats();
    for (int i = 0; i < 3; i++) wq.push_back('{a: 16'h0060 + 16'(i), d: 16'h1234});
    exp_mem[8'h60] = 16'h1234;
    exp_mem[8'h61] = 16'h1234;
    start = 1'b1; mode = 1'b1; dst_addr = 16'h0060; length = 9'd5; fill_value = 16'h1234;
    step();
    start = 1'b0;
    step();
    step();
    chk("pre_rst_words_done", 32'(words_done), 32'd2);
    rst = 1'b1;
    #1;
    chk("we_gated_by_rst", 32'(mem_write_en), 32'd0);
    step();
    chk("rst_mid_flags", {28'd0, busy, done, mem_read, mem_write_en}, 32'd0);
    chk("rst_mid_words_done", 32'(words_done), 32'd0);
    rst = 1'b0;
    step();
    step();
    chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
    chk("rst_mid_scoreboard", 32'(wq.size()), 32'd0);
    check_mem("rst_mid_mem_image");
    $display("reset mid-fill: words written before reset checked");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
